ssemi_adc_decimator_cfg_sequencer: RTL and testbench
====================================================

# ssemi_adc_decimator_cfg_sequencer

Boot-time configuration sequencer for the ADC decimator subsystem. On a start request it streams a coefficient/config table into the decimator's CSR write port, writes the control register to enable the datapath, then polls the status register until the decimator reports running. It owns the decimator CSR port while busy and reports done or error to the system controller.

## Interface
Parameters:
- NUM_WORDS, 16: number of table entries written (1–256).
- TBL_AW, 4: table index width, must hold NUM_WORDS-1.
- CTRL_ADDR, 8'h00: control register address.
- CTRL_ENABLE, 32'h0000_0001: value written to CTRL_ADDR after the table.
- STATUS_ADDR, 8'h04: status register address; bit 0 = running.
- POLL_LIMIT, 255: maximum status reads before timeout (1–65535).

Ports:
- i_clk  in  1  system clock (≤100 MHz).
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start request, sampled in IDLE only.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse on successful completion.
- o_error  out  1  sticky error flag.
- o_err_code  out  2  0 none, 1 timeout, 2 decimator error, 3 readback mismatch.
- o_tbl_idx  out  TBL_AW  table read index.
- i_tbl_addr  in  8  CSR address of entry o_tbl_idx (combinational, same cycle).
- i_tbl_data  in  32  CSR data of entry o_tbl_idx (combinational, same cycle).
- o_csr_wr_valid  out  1  CSR write valid.
- o_csr_addr  out  8  CSR address (shared by write and read).
- o_csr_wr_data  out  32  CSR write data.
- i_csr_wr_ready  in  1  CSR write ready.
- o_csr_rd_ready  out  1  CSR read strobe.
- i_csr_rd_data  in  32  CSR read data, valid in the same cycle as o_csr_rd_ready.
- i_dec_error  in  1  decimator error interrupt.

## Operation
- States: IDLE, LOAD, ENABLE, POLL, DONE, ERR (plus VERIFY when readback is compiled in).
- IDLE: all strobes low. i_start=1 → LOAD, clear o_error/o_err_code, index=0, poll count=0.
- LOAD: o_csr_wr_valid=1, o_csr_addr=i_tbl_addr, o_csr_wr_data=i_tbl_data, o_tbl_idx=index. A write transfers when valid and ready are both high. After the transfer, index+1; after index NUM_WORDS-1 transfers → ENABLE. Address and data stay stable while ready is low.
- ENABLE: write CTRL_ENABLE to CTRL_ADDR with the same handshake. On transfer → POLL.
- POLL: o_csr_rd_ready=1, o_csr_addr=STATUS_ADDR. If i_csr_rd_data[0]=1 → DONE. Otherwise count+1. When the count reaches POLL_LIMIT → ERR, code 1.
- DONE: o_done=1 for one cycle → IDLE.
- ERR: o_error=1 (sticky), o_busy=0 → IDLE the next cycle. The error stays set until the next accepted i_start or reset.
- i_dec_error=1 in LOAD/ENABLE/POLL/VERIFY → ERR, code 2. This takes priority over a transfer completing in the same cycle; that transfer still counts on the bus but is not counted internally.
- i_start while busy is ignored.
- o_busy=1 in LOAD, ENABLE, POLL and VERIFY.

## Timing
- Reset: state IDLE. All outputs 0: o_busy, o_done, o_error, o_err_code, o_tbl_idx, o_csr_wr_valid, o_csr_addr, o_csr_wr_data, o_csr_rd_ready. Counters 0.
- Reset mid-sequence aborts at the next edge. Strobes drop in the cycle after i_rst is sampled. No partial write is completed.
- All control outputs are registered state decodes. CSR address and data pass combinationally from table to port in LOAD.
- Latency with ready always high: i_start at cycle 0 → first write at cycle 1, one write per cycle. Enable write at NUM_WORDS+1, first poll at NUM_WORDS+2. If status is already running, o_done at NUM_WORDS+3.
- Each extra cycle with i_csr_wr_ready=0 adds one cycle.

## Configuration
- SSEMI_ADC_DECIMATOR_CFG_READBACK_EN defined:
  - After each LOAD transfer, go to VERIFY for one cycle: o_csr_rd_ready=1 at the same address.
  - If i_csr_rd_data equals the written data → next entry. If not → ERR, code 3, with o_tbl_idx frozen at the failing index.
  - Each table word costs 2 cycles. The ENABLE write is not read back.
- Not defined: no VERIFY state, code 3 is never produced, and the table streams at one word per cycle.

## Test plan
- NUM_WORDS=16, ready tied high, status bit0=1 on the first read → 16 writes at cycles 1–16, CTRL write of 32'h1 at cycle 17, o_done pulse at cycle 19.
- i_csr_wr_ready low for 3 cycles on entry 5 → addr/data held constant, no skipped or duplicated index, done delayed exactly 3 cycles.
- Status bit0 never set, POLL_LIMIT=4 → exactly 4 reads, then o_error=1, o_err_code=1, o_busy=0.
- i_dec_error pulsed during LOAD at index 7 → ERR code 2 on the next cycle. A re-issued i_start clears o_error and restarts at index 0.
- i_rst asserted at index 9 → all outputs 0 the next cycle. i_start issued during busy → ignored, no restart.
- READBACK_EN defined, readback of entry 3 corrupted → o_err_code=3, o_tbl_idx=3, and no ENABLE write issued.

Source files
------------

// File: rtl/ssemi_adc_decimator_cfg_sequencer.sv
// Boot-time config sequencer: streams a CSR table into the ADC decimator, enables it, polls for running.
// Optional readback verification of each table word: define SSEMI_ADC_DECIMATOR_CFG_READBACK_EN.
module ssemi_adc_decimator_cfg_sequencer #(
  parameter int          NUM_WORDS   = 16,
  parameter int          TBL_AW      = 4,
  parameter logic [7:0]  CTRL_ADDR   = 8'h00,
  parameter logic [31:0] CTRL_ENABLE = 32'h0000_0001,
  parameter logic [7:0]  STATUS_ADDR = 8'h04,
  parameter int          POLL_LIMIT  = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [TBL_AW-1:0] o_tbl_idx,
  input  logic [7:0]        i_tbl_addr,
  input  logic [31:0]       i_tbl_data,
  output logic              o_csr_wr_valid,
  output logic [7:0]        o_csr_addr,
  output logic [31:0]       o_csr_wr_data,
  input  logic              i_csr_wr_ready,
  output logic              o_csr_rd_ready,
  input  logic [31:0]       i_csr_rd_data,
  input  logic              i_dec_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ENABLE, S_POLL, S_DONE, S_ERR, S_VERIFY
  } state_t;

  localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_WORDS - 1);
  localparam logic [15:0]       POLL_MAX = 16'(POLL_LIMIT);

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_valid_q, wr_valid_d;
  logic              rd_ready_q, rd_ready_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
          error_d = 1'b0;
          code_d  = 2'd0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        // decimator fault wins over a same-cycle transfer; the index is not advanced
        if (i_dec_error) begin
          state_d = S_ERR;
          code_d  = 2'd2;
        end else if (i_csr_wr_ready) begin
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
          state_d = S_VERIFY;
`else
          if (idx_q == LAST_IDX) state_d = S_ENABLE;
          else                   idx_d   = idx_q + TBL_AW'(1);
`endif
        end
      end
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
      S_VERIFY: begin
        if (i_dec_error) begin
          state_d = S_ERR;
          code_d  = 2'd2;
        end else if (i_csr_rd_data != i_tbl_data) begin
          state_d = S_ERR;
          code_d  = 2'd3;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_ENABLE;
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + TBL_AW'(1);
        end
      end
`endif
      S_ENABLE: begin
        if (i_dec_error) begin
          state_d = S_ERR;
          code_d  = 2'd2;
        end else if (i_csr_wr_ready) begin
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (i_dec_error) begin
          state_d = S_ERR;
          code_d  = 2'd2;
        end else if (i_csr_rd_data[0]) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == POLL_MAX) begin
            state_d = S_ERR;
            code_d  = 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) error_d = 1'b1;

    // strobes are decoded from the next state so they come straight off flops
    busy_d     = (state_d == S_LOAD) || (state_d == S_ENABLE) ||
                 (state_d == S_POLL) || (state_d == S_VERIFY);
    done_d     = (state_d == S_DONE);
    wr_valid_d = (state_d == S_LOAD) || (state_d == S_ENABLE);
    rd_ready_d = (state_d == S_POLL) || (state_d == S_VERIFY);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      code_q     <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  // table address/data pass through combinationally while loading
  always_comb begin
    o_csr_addr    = 8'h00;
    o_csr_wr_data = 32'h0;
    case (state_q)
      S_LOAD: begin
        o_csr_addr    = i_tbl_addr;
        o_csr_wr_data = i_tbl_data;
      end
      S_VERIFY: o_csr_addr = i_tbl_addr;
      S_ENABLE: begin
        o_csr_addr    = CTRL_ADDR;
        o_csr_wr_data = CTRL_ENABLE;
      end
      S_POLL:  o_csr_addr = STATUS_ADDR;
      default: ;
    endcase
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_err_code     = code_q;
  assign o_tbl_idx      = idx_q;
  assign o_csr_wr_valid = wr_valid_q;
  assign o_csr_rd_ready = rd_ready_q;

endmodule

// File: tb/tb_ssemi_adc_decimator_cfg_sequencer.sv
// Directed table-driven bench for the decimator config sequencer (NUM_WORDS=16, POLL_LIMIT=4).
module tb_ssemi_adc_decimator_cfg_sequencer;

  localparam int W = 16;
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int B = W * (1 + RB);

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_csr_wr_ready, i_dec_error;
  logic [31:0] i_csr_rd_data;
  logic        o_busy, o_done, o_error, o_csr_wr_valid, o_csr_rd_ready;
  logic [1:0]  o_err_code;
  logic [3:0]  o_tbl_idx;
  logic [7:0]  i_tbl_addr, o_csr_addr;
  logic [31:0] i_tbl_data, o_csr_wr_data;

  always #5 clk = ~clk;

  function automatic logic [31:0] tdata(input int i);
    return 32'hC0DE_0000 | 32'(i * 257);
  endfunction

  assign i_tbl_addr = 8'h10 + {4'h0, o_tbl_idx};
  assign i_tbl_data = tdata(int'(o_tbl_idx));

  ssemi_adc_decimator_cfg_sequencer #(
    .NUM_WORDS(W), .TBL_AW(4), .CTRL_ADDR(8'h00), .CTRL_ENABLE(32'h1),
    .STATUS_ADDR(8'h04), .POLL_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_err_code(o_err_code), .o_tbl_idx(o_tbl_idx),
    .i_tbl_addr(i_tbl_addr), .i_tbl_data(i_tbl_data), .o_csr_wr_valid(o_csr_wr_valid),
    .o_csr_addr(o_csr_addr), .o_csr_wr_data(o_csr_wr_data), .i_csr_wr_ready(i_csr_wr_ready),
    .o_csr_rd_ready(o_csr_rd_ready), .i_csr_rd_data(i_csr_rd_data), .i_dec_error(i_dec_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {13'b0, o_busy, o_done, o_error, o_err_code, o_tbl_idx, o_csr_wr_valid,
            o_csr_addr, o_csr_wr_data, o_csr_rd_ready};
  endfunction

  // results of one sequence run
  int r_done, r_err, r_code, r_writes, r_reads, r_bad, r_err_idx, r_en, r_to, r_busy_err;
  logic [31:0] mem [256];

  task automatic run_seq(input int stall_idx, input int stall_n, input int status_delay,
                         input int dec_idx, input int start_cyc, input int corrupt_idx);
    int wi, stall_left, c;
    logic holding, dec_fired;
    logic [7:0]  ha, ea;
    logic [31:0] hd, ed;
    r_done = 0; r_err = 0; r_code = 0; r_reads = 0; r_bad = 0; r_err_idx = -1;
    r_en = 0; r_to = 1; r_busy_err = 0;
    wi = 0; stall_left = stall_n; holding = 0; dec_fired = 0; ha = 0; hd = 0;
    @(negedge clk);
    i_start = 1'b1;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      i_start = (c == start_cyc);
      i_dec_error = 1'b0;
      i_csr_wr_ready = 1'b1;
      i_csr_rd_data = 32'h0;
      if (holding && (!o_csr_wr_valid || o_csr_addr != ha || o_csr_wr_data != hd)) r_bad++;
      holding = 0;
      if (o_csr_wr_valid) begin
        if (o_csr_addr != 8'h00 && int'(o_tbl_idx) == stall_idx && stall_left > 0) begin
          i_csr_wr_ready = 1'b0;
          stall_left--;
          holding = 1;
          ha = o_csr_addr;
          hd = o_csr_wr_data;
        end
        if (o_csr_addr != 8'h00 && int'(o_tbl_idx) == dec_idx && !dec_fired) begin
          i_dec_error = 1'b1;
          dec_fired = 1;
        end
        if (i_csr_wr_ready) begin
          ea = (wi < W) ? 8'(8'h10 + wi) : 8'h00;
          ed = (wi < W) ? tdata(wi) : 32'h1;
          if (o_csr_addr != ea || o_csr_wr_data != ed) r_bad++;
          mem[o_csr_addr] = o_csr_wr_data;
          if (o_csr_addr == 8'h00) r_en = 1;
          wi++;
        end
      end
      if (o_csr_rd_ready) begin
        if (o_csr_addr == 8'h04) begin
          r_reads++;
          i_csr_rd_data = (r_reads > status_delay) ? 32'h1 : 32'h0;
        end else begin
          i_csr_rd_data = mem[o_csr_addr] ^ ((int'(o_tbl_idx) == corrupt_idx) ? 32'h100 : 32'h0);
        end
      end
      if (o_done) r_done = c;
      if (o_error && r_err == 0) begin
        r_err = c; r_code = int'(o_err_code); r_err_idx = int'(o_tbl_idx); r_busy_err = int'(o_busy);
      end
      if (c > 1 && !o_busy) begin
        r_to = 0;
        break;
      end
    end
    r_writes = wi;
    i_start = 1'b0; i_dec_error = 1'b0; i_csr_wr_ready = 1'b1; i_csr_rd_data = 32'h0;
  endtask

  typedef struct {
    string name;
    int stall_idx, stall_n, status_delay, dec_idx, start_cyc;
    int exp_done, exp_err, exp_code, exp_writes, exp_reads;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"happy",   -1, 0, 0,    -1, -1, B + 3, 0,             0, W + 1, 1};
    vecs[1] = '{"stall5",   5, 3, 0,    -1, -1, B + 6, 0,             0, W + 1, 1};
    vecs[2] = '{"poll3",   -1, 0, 2,    -1,  5, B + 5, 0,             0, W + 1, 3};
    vecs[3] = '{"timeout", -1, 0, 1000, -1, -1, 0,     B + 6,         1, W + 1, 4};
    vecs[4] = '{"decerr",  -1, 0, 0,     7, -1, 0,     2 + (1+RB)*7,  2, 8,     0};

    i_rst = 1'b1; i_start = 1'b0; i_csr_wr_ready = 1'b1; i_dec_error = 1'b0; i_csr_rd_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    i_rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].stall_idx, vecs[v].stall_n, vecs[v].status_delay,
              vecs[v].dec_idx, vecs[v].start_cyc, -1);
      chk({vecs[v].name, "_finish"}, 64'(r_to), 64'd0);
      chk({vecs[v].name, "_done_cyc"}, 64'(r_done), 64'(vecs[v].exp_done));
      chk({vecs[v].name, "_err_cyc"}, 64'(r_err), 64'(vecs[v].exp_err));
      chk({vecs[v].name, "_err_code"}, 64'(r_code), 64'(vecs[v].exp_code));
      chk({vecs[v].name, "_writes"}, 64'(r_writes), 64'(vecs[v].exp_writes));
      chk({vecs[v].name, "_status_reads"}, 64'(r_reads), 64'(vecs[v].exp_reads));
      chk({vecs[v].name, "_bus_order_hold"}, 64'(r_bad), 64'd0);
      if (vecs[v].exp_err != 0) begin
        chk({vecs[v].name, "_busy_at_err"}, 64'(r_busy_err), 64'd0);
        repeat (2) @(negedge clk);
        chk({vecs[v].name, "_sticky"}, {62'b0, o_error, o_busy}, 64'h2);
      end
    end

    // restart after decimator error: error clears, index restarts at 0
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk("restart_state", {56'b0, o_error, o_err_code, o_tbl_idx, o_csr_wr_valid},
        {56'b0, 1'b0, 2'd0, 4'd0, 1'b1});
    i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;

    // reset mid-sequence at index 9
    begin
      int n;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      for (n = 0; n < 100; n++) begin
        if (o_csr_wr_valid && o_tbl_idx == 4'd9) break;
        @(negedge clk);
      end
      chk("reach_idx9", 64'(n < 100), 64'd1);
      i_rst = 1'b1;
      @(negedge clk);
      chk("midseq_reset_outputs", all_outs(), 64'h0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {62'b0, o_busy, o_csr_wr_valid}, 64'h0);
    end

`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
    run_seq(-1, 0, 0, -1, -1, 3);
    chk("rb_finish", 64'(r_to), 64'd0);
    chk("rb_err_code", 64'(r_code), 64'd3);
    chk("rb_err_idx", 64'(r_err_idx), 64'd3);
    chk("rb_err_cyc", 64'(r_err), 64'd9);
    chk("rb_no_enable", 64'(r_en), 64'd0);
    chk("rb_writes", 64'(r_writes), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
